// File: rtl/spi_master_pkg.sv
// Shared SPI master definitions: clock-generator state encoding and the
// default divider width used by the clock generator and the register file.
package spi_master_pkg;

  localparam int unsigned SPI_DIV_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } clkgen_state_e;

endpackage

// File: rtl/spi_master_clkgen.sv
// SPI serial-clock generator (CPOL=0). Divides clk by 2*(div_q+1) and emits
// one-cycle spi_rise / spi_fall strobes aligned with the spi_clk transitions.
// A low half-period is abandoned immediately on stop; a high half-period is
// always completed so the transmitter sees as many falls as rises.
module spi_master_clkgen
  import spi_master_pkg::*;
#(
  parameter int unsigned DIV_W = SPI_DIV_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic [DIV_W-1:0] clk_div,
  input  logic             clk_div_valid,
  output logic             spi_clk,
  output logic             spi_fall,
  output logic             spi_rise,
  output logic             clk_idle
);

  clkgen_state_e    state_q;
  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_pend_q;
  logic             pend_q;
  logic [DIV_W-1:0] cnt_q;
  logic             spi_clk_q;
  logic             spi_rise_q;
  logic             spi_fall_q;

  logic [DIV_W-1:0] cnt_d;
  logic             half_done;
  logic             div_load_en;
  logic [DIV_W-1:0] div_load_d;

  // Counter increment, half-period terminal count and the divider value to
  // install when idle (a fresh strobe wins over an older shadowed value).
  always_comb begin
    cnt_d       = cnt_q + DIV_W'(1);
    half_done   = (cnt_q == div_q);
    div_load_en = clk_div_valid | pend_q;
    div_load_d  = clk_div_valid ? clk_div : div_pend_q;
  end

  // Clock-generator FSM: half-period counter, divider shadowing and the
  // registered spi_clk / strobe outputs.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      div_q      <= '0;
      div_pend_q <= '0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      spi_clk_q  <= 1'b0;
      spi_rise_q <= 1'b0;
      spi_fall_q <= 1'b0;
    end else begin
      spi_rise_q <= 1'b0;
      spi_fall_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q     <= '0;
          spi_clk_q <= 1'b0;
          // Divider may only change here, so a same-cycle en uses the new value.
          if (div_load_en) begin
            div_q  <= div_load_d;
            pend_q <= 1'b0;
          end
          if (en) begin
            state_q <= RUN;
          end
        end

        RUN: begin
          if (clk_div_valid) begin
            div_pend_q <= clk_div;
            pend_q     <= 1'b1;
          end
          if (!en && !spi_clk_q) begin
            // Stopping from the low phase is immediate; no edge is emitted.
            state_q <= IDLE;
            cnt_q   <= '0;
            if (div_load_en) begin
              div_q  <= div_load_d;
              pend_q <= 1'b0;
            end
          end else if (half_done) begin
            cnt_q      <= '0;
            spi_clk_q  <= ~spi_clk_q;
            spi_rise_q <= ~spi_clk_q;
            spi_fall_q <= spi_clk_q;
            // High phase finishing exactly as en drops: this fall ends the run.
            if (spi_clk_q && !en) begin
              state_q <= IDLE;
              if (div_load_en) begin
                div_q  <= div_load_d;
                pend_q <= 1'b0;
              end
            end
          end else begin
            cnt_q <= cnt_d;
            if (!en) begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (clk_div_valid) begin
            div_pend_q <= clk_div;
            pend_q     <= 1'b1;
          end
          if (half_done) begin
            cnt_q      <= '0;
            spi_clk_q  <= 1'b0;
            spi_fall_q <= 1'b1;
            state_q    <= IDLE;
            if (div_load_en) begin
              div_q  <= div_load_d;
              pend_q <= 1'b0;
            end
          end else begin
            cnt_q <= cnt_d;
          end
        end

        default: begin
          state_q   <= IDLE;
          cnt_q     <= '0;
          spi_clk_q <= 1'b0;
        end
      endcase
    end
  end

  assign spi_clk  = spi_clk_q;
  assign spi_rise = spi_rise_q;
  assign spi_fall = spi_fall_q;
  assign clk_idle = (state_q == IDLE);

endmodule

// File: tb/tb_spi_master_clkgen.sv
// Self-checking bench for spi_master_clkgen: per-cycle expectations are
// derived from the half-period timing formula and queued on a scoreboard.
module tb_spi_master_clkgen;
  import spi_master_pkg::*;

  localparam int DIV_W = SPI_DIV_W;

  logic             clk = 1'b0;
  logic             rstn;
  logic             en;
  logic [DIV_W-1:0] clk_div;
  logic             clk_div_valid;
  logic             spi_clk;
  logic             spi_fall;
  logic             spi_rise;
  logic             clk_idle;

  always #5 clk = ~clk;

  spi_master_clkgen #(.DIV_W(DIV_W)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .en            (en),
    .clk_div       (clk_div),
    .clk_div_valid (clk_div_valid),
    .spi_clk       (spi_clk),
    .spi_fall      (spi_fall),
    .spi_rise      (spi_rise),
    .clk_idle      (clk_idle)
  );

  // Expected {spi_clk, spi_rise, spi_fall, clk_idle} after one clock edge.
  typedef struct {
    logic [3:0] outs;
    string      tag;
  } exp_t;

  // Table row: divider, cycles with en held, total rises / falls per run.
  typedef struct {
    int div;
    int n_en;
    int exp_rises;
    int exp_falls;
  } vec_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   rise_cnt = 0;
  int   fall_cnt = 0;

  // spi_clk level after the k-th edge following the edge that samples en=1.
  function automatic logic model_clk(int d, int k);
    return ((k / (d + 1)) % 2) == 1;
  endfunction

  task automatic push_exp(input logic c, input logic r, input logic f,
                          input logic i, input string tag);
    exp_t e;
    e.outs = {c, r, f, i};
    e.tag  = tag;
    sb_q.push_back(e);
  endtask

  task automatic tick();
    exp_t       e;
    logic [3:0] act;
    @(posedge clk);
    #1;
    act = {spi_clk, spi_rise, spi_fall, clk_idle};
    rise_cnt += int'(spi_rise);
    fall_cnt += int'(spi_fall);
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got clk/rise/fall/idle=%b, no expectation queued", act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e.outs) begin
        n_fail++;
        $display("FAIL %s @%0t: got clk/rise/fall/idle=%b expected %b", e.tag, $time, act, e.outs);
      end
    end
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic load_div(input int d);
    clk_div       = DIV_W'(d);
    clk_div_valid = 1'b1;
    en            = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, "load_div");
    tick();
    clk_div_valid = 1'b0;
  endtask

  // Hold en for n edges (optionally strobing clk_div at edges sk1/sk2), then
  // optionally drop en and follow the stop / drain sequence back to IDLE.
  task automatic run_en(input int d, input int n, input bit stop,
                        input int sk1, input int sv1, input int sk2, input int sv2);
    logic c;
    logic prev;
    en = 1'b1;
    for (int k = 0; k < n; k++) begin
      clk_div_valid = (k == sk1) || (k == sk2);
      clk_div       = (k == sk2) ? DIV_W'(sv2) : DIV_W'(sv1);
      c    = model_clk(d, k);
      prev = (k == 0) ? 1'b0 : model_clk(d, k - 1);
      push_exp(c, c & ~prev, ~c & prev, 1'b0, "run");
      tick();
    end
    clk_div_valid = 1'b0;
    if (stop) begin
      en = 1'b0;
      if (!model_clk(d, n - 1)) begin
        push_exp(1'b0, 1'b0, 1'b0, 1'b1, "stop_low");
        tick();
      end else begin
        for (int j = 0; j < 1024; j++) begin
          if (model_clk(d, n + j)) begin
            push_exp(1'b1, 1'b0, 1'b0, 1'b0, "drain_high");
            tick();
          end else begin
            push_exp(1'b0, 1'b0, 1'b1, 1'b1, "drain_fall");
            tick();
            break;
          end
        end
        push_exp(1'b0, 1'b0, 1'b0, 1'b1, "idle_after_drain");
        tick();
      end
    end
  endtask

  vec_t vecs[6];

  initial begin
    vecs[0] = '{div: 3,   n_en: 40,  exp_rises: 5, exp_falls: 5};
    vecs[1] = '{div: 0,   n_en: 10,  exp_rises: 5, exp_falls: 5};
    vecs[2] = '{div: 1,   n_en: 9,   exp_rises: 2, exp_falls: 2};
    vecs[3] = '{div: 3,   n_en: 5,   exp_rises: 1, exp_falls: 1};
    vecs[4] = '{div: 4,   n_en: 3,   exp_rises: 0, exp_falls: 0};
    vecs[5] = '{div: 255, n_en: 300, exp_rises: 1, exp_falls: 1};

    rstn          = 1'b0;
    en            = 1'b0;
    clk_div       = '0;
    clk_div_valid = 1'b0;

    // Reset state
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, "reset");
    tick();
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, "reset_hold");
    tick();
    rstn = 1'b1;

    // Table-driven runs
    for (int v = 0; v < 6; v++) begin
      load_div(vecs[v].div);
      rise_cnt = 0;
      fall_cnt = 0;
      run_en(vecs[v].div, vecs[v].n_en, 1'b1, -1, 0, -1, 0);
      check_int($sformatf("vec%0d_rises", v), rise_cnt, vecs[v].exp_rises);
      check_int($sformatf("vec%0d_falls", v), fall_cnt, vecs[v].exp_falls);
    end

    // Divider writes while running are shadowed; last write wins after idle
    load_div(2);
    rise_cnt = 0;
    fall_cnt = 0;
    run_en(2, 20, 1'b1, 3, 5, 9, 7);
    check_int("shadow_run_rises", rise_cnt, 3);
    check_int("shadow_run_falls", fall_cnt, 3);
    rise_cnt = 0;
    fall_cnt = 0;
    run_en(7, 20, 1'b1, -1, 0, -1, 0);
    check_int("shadow_applied_rises", rise_cnt, 1);
    check_int("shadow_applied_falls", fall_cnt, 1);

    // Reset in the middle of a high phase
    load_div(4);
    run_en(4, 7, 1'b0, -1, 0, -1, 0);
    rstn = 1'b0;
    en   = 1'b0;
    push_exp(1'b0, 1'b0, 1'b0, 1'b1, "reset_mid_high");
    tick();
    rstn     = 1'b1;
    rise_cnt = 0;
    fall_cnt = 0;
    run_en(0, 6, 1'b1, -1, 0, -1, 0);
    check_int("post_reset_rises", rise_cnt, 3);
    check_int("post_reset_falls", fall_cnt, 3);

    // Same-cycle en and divider strobe from IDLE
    rise_cnt = 0;
    fall_cnt = 0;
    run_en(1, 12, 1'b1, 0, 1, -1, 0);
    check_int("same_cycle_rises", rise_cnt, 3);
    check_int("same_cycle_falls", fall_cnt, 3);

    check_int("scoreboard_drained", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
